// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM state encoding.
package adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_fa4.sv
// Combinational NIB_W-bit full adder with carry-in and carry-out; the only arithmetic
// slice in the nibble-serial adder.
module nibble_fa4
  import adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
  assign s     = total[NIB_W-1:0];
  assign cout  = total[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a single nibble_fa4 slice.
// Optional macro NIBBLE_SERIAL_SUB_EN adds a `sub` port for two's-complement a - b.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  generate
    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q;
  logic             accept;
  logic             sub_sel;
  logic             cin0;
  logic [NIB_W-1:0] a_nib, b_nib, b_nib_eff, s_nib;
  logic             c_nib;

`ifdef NIBBLE_SERIAL_SUB_EN
  logic sub_q;

  always_ff @(posedge clk) begin
    if (accept) sub_q <= sub;
  end

  assign sub_sel = sub_q;
  assign cin0    = sub;
`else
  assign sub_sel = 1'b0;
  assign cin0    = 1'b0;
`endif

  assign accept = in_valid & in_ready;

  // Control FSM: decode handshakes and status from the current state.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cnt_q == LAST_NIB) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Nibble select: pick operand nibble cnt_q and merge the slice result back into sum.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    sum_d = sum_q;
    for (int k = 0; k < NIBBLES; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        a_nib = a_q[k*NIB_W +: NIB_W];
        b_nib = b_q[k*NIB_W +: NIB_W];
        sum_d[k*NIB_W +: NIB_W] = s_nib;
      end
    end
  end

  assign b_nib_eff = b_nib ^ {NIB_W{sub_sel}};

  nibble_fa4 u_fa4 (
    .a    (a_nib),
    .b    (b_nib_eff),
    .cin  (carry_q),
    .s    (s_nib),
    .cout (c_nib)
  );

  // Operand capture: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // State, counter, carry and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= '0;
        carry_q <= cin0;
      end else if (state_q == ST_RUN) begin
        sum_q   <= sum_d;
        carry_q <= c_nib;
        // Counter parks on the last nibble rather than wrapping.
        if (cnt_q == LAST_NIB) cout_q <= c_nib;
        else                   cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed, table-driven bench for nibble_serial_adder (WIDTH = 16), with hand-written
// sequences for backpressure, ignored input during RUN, and reset mid-operation.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         sub_r;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef NIBBLE_SERIAL_SUB_EN
    .sub       (sub_r),
`endif
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] esum;
    logic         ecout;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic accept_op(input logic [W-1:0] va, input logic [W-1:0] vb);
    wait_in_ready();
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
  endtask

  task automatic wait_out_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] esum, input logic ecout);
    int lat;
    accept_op(va, vb);
    wait_out_valid(lat);
    check({name, "_latency"}, lat, 4);
    check({name, "_sum"}, {16'd0, sum}, {16'd0, esum});
    check({name, "_cout"}, {31'd0, carry_out}, {31'd0, ecout});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [W-1:0] held_sum;
    logic         held_cout;

    vecs[0] = '{16'h1234, 16'h1111, 16'h2345, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
    vecs[4] = '{16'h0F0F, 16'h00F1, 16'h1000, 1'b0};
    vecs[5] = '{16'hABCD, 16'h1234, 16'hBE01, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    vecs[7] = '{16'h7FFF, 16'h0001, 16'h8000, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sub_r     = 1'b0;
    a         = '0;
    b         = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_sum", {16'd0, sum}, 32'd0);
    check("reset_cout", {31'd0, carry_out}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].esum, vecs[i].ecout);
    end

    // Backpressure in DONE, with new operands offered that must be ignored.
    accept_op(16'h1234, 16'h1111);
    wait_out_valid(lat);
    check("bp_latency", lat, 4);
    held_sum  = sum;
    held_cout = carry_out;
    check("bp_sum", {16'd0, held_sum}, 32'h2345);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      a        = 16'hAAAA;
      b        = 16'h5555;
      tick();
      check("bp_hold_sum", {16'd0, sum}, {16'd0, held_sum});
      check("bp_hold_flags", {28'd0, out_valid, in_ready, busy, carry_out},
            {28'd0, 1'b1, 1'b0, 1'b1, held_cout});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release", {29'd0, in_ready, out_valid, busy}, 32'd4);
    tick();
    check("bp_no_stale_accept", {31'd0, busy}, 32'd0);

    // in_valid during RUN is ignored; out_ready held high throughout has no early effect.
    out_ready = 1'b1;
    accept_op(16'h1234, 16'h1111);
    check("run_busy", {30'd0, busy, in_ready}, 32'd2);
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    lat = 2;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("ign_latency", lat, 4);
    check("ign_sum", {16'd0, sum}, 32'h2345);
    check("ign_cout", {31'd0, carry_out}, 32'd0);
    tick();
    out_ready = 1'b0;
    check("ign_back_idle", {30'd0, in_ready, out_valid}, 32'd2);

    // Reset during the second RUN cycle aborts the operation.
    accept_op(16'h1234, 16'h1111);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
    check("rst_mid_sum", {16'd0, sum}, 32'd0);
    check("rst_mid_cout", {31'd0, carry_out}, 32'd0);
    run_op("after_rst", 16'h0001, 16'h0001, 16'h0002, 1'b0);

    // Reset while in DONE drops the result.
    accept_op(16'hFFFF, 16'h0001);
    wait_out_valid(lat);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_done_flags", {28'd0, in_ready, out_valid, busy, carry_out}, 32'd8);

`ifdef NIBBLE_SERIAL_SUB_EN
    sub_r = 1'b1;
    run_op("sub_5_7", 16'h0005, 16'h0007, 16'hFFFE, 1'b0);
    run_op("sub_7_5", 16'h0007, 16'h0005, 16'h0002, 1'b1);
    sub_r = 1'b0;
    run_op("add_after_sub", 16'h0007, 16'h0005, 16'h000C, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
